instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Prefetching instruction fetch stage directly upstream of the core's decode/register-read path.
- Generates sequential PCs and issues single-outstanding requests to a variable-latency instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush of buffered and in-flight fetches.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  fetch enable; low stops new requests, does not abort in-flight
imem_req_o  out  1  request to instruction memory
imem_addr_o  out  32  request byte address, word aligned
imem_ack_i  in  1  memory response valid, sampled only while imem_req_o=1
imem_data_i  in  32  instruction word, valid with imem_ack_i
redirect_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  32  new PC; bits[1:0] forced to 0
instr_valid_o  out  1  FIFO head valid
instr_o  out  32  FIFO head instruction; 0 when empty
instr_pc_o  out  32  PC of FIFO head; 0 when empty
instr_ready_i  in  1  decode accepts head this cycle
count_o  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_i=0, async): imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, count_o=0, fetch PC=RESET_PC, FSM=IDLE.
- FSM states: IDLE, REQ, DISCARD.
- IDLE -> REQ when start_i=1 and count+0 < DEPTH. imem_req_o rises the next cycle with imem_addr_o=fetch PC.
- REQ: imem_req_o and imem_addr_o held stable until imem_ack_i. Ack is legal from the first cycle req is high; latency is unbounded.
- On ack in REQ: {PC, data} written to FIFO (visible at head next cycle) and fetch PC += 4, wrapping 32'hFFFF_FFFC -> 0.
  - Next cycle: stay in REQ with the new address (back-to-back, 1 word/cycle peak) if start_i=1 and occupancy after this write and any same-cycle pop < DEPTH.
  - Otherwise drop req and go to IDLE.
- Space is reserved at issue, so the FIFO never overflows. Write-when-full cannot occur; assert it in sim.
- Pop: instr_valid_o & instr_ready_i. Head advances next cycle. Simultaneous push and pop leaves count unchanged.
- Empty: instr_valid_o=0, instr_o=0, instr_pc_o=0. instr_ready_i is ignored.
- redirect_i (highest priority, any state):
  - FIFO cleared next cycle. A same-cycle pop is void; decode must not commit it.
  - fetch PC <= {redirect_pc_i[31:2],2'b00}.
  - In REQ with no ack this cycle -> DISCARD. imem_req_o stays high at the old address until ack; that data is dropped, not written. Then REQ at the redirect PC (if start_i=1), else IDLE.
  - In REQ with ack the same cycle: data dropped, next cycle REQ at the redirect PC.
  - In IDLE: next request uses the redirect PC.
  - A second redirect in DISCARD overwrites the pending PC; last one wins.
- start_i falling in REQ: current request completes and its data is written; no further issue.
- rst_i asserted mid-transaction aborts immediately. The memory side must tolerate the req drop.
- count_o is registered and equals the number of valid FIFO entries.

Decomposition:
- Package fetch_pkg:
  - XLEN=32
  - PC_INC=4
  - fetch_state_t enum {IDLE, REQ, DISCARD}
  - FETCH_RESET_PC default constant
  - entry struct {pc[31:0], instr[31:0]}
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of 64-bit entries. Ports: push, pop, flush, head, count.
  - Flush dominates push/pop.
  - Active-low async reset.
- FSM and PC logic stay in instr_fetch_unit.

Test Plan:
- Reset then start_i=1, ack every cycle, ready=1 -> req addresses 0x0,0x4,0x8,...; instr_valid_o from the cycle after first ack; instr_pc_o tracks 0x0,0x4,0x8 with matching data.
- ready=0, ack immediate, DEPTH=4 -> exactly 4 requests (0x0..0xC), req drops, count_o=4. ready=1 for one cycle -> count_o=3, one new req at 0x10.
- Ack latency 3 cycles -> imem_addr_o stable 3 cycles, one word per 4 cycles, no duplicate or missing PCs.
- redirect_i with redirect_pc_i=0x103 while req at 0x8 is pending (ack 2 cycles later) -> ack data dropped, count_o=0, next req addr=0x100, first instr_pc_o=0x100.
- redirect_i same cycle as ack at 0x20 and a pop -> FIFO empty next cycle, 0x20 data never appears, next req 0x200 with redirect_pc_i=0x200.
- Fetch PC at 0xFFFF_FFFC, ack -> next req addr 0x0000_0000. rst_i low mid-REQ -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, instr} pairs; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  fetch_entry_t  mem [DEPTH];

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= entry;
  end

  // Space is reserved before a request is issued, so a write into a full FIFO is a design bug.
  assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> ((count < CW'(DEPTH)) || do_pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetching fetch stage: sequential PC generation, single-outstanding imem requests,
// FIFO buffering toward decode and redirect with flush of buffered/in-flight words.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   imem_req_o,
  output logic [XLEN-1:0]        imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [XLEN-1:0]        imem_data_i,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic                   instr_valid_o,
  output logic [XLEN-1:0]        instr_o,
  output logic [XLEN-1:0]        instr_pc_o,
  input  logic                   instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] redirect_target;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic [CW:0]     occ_after;
  logic            has_room;
  logic            room_after;

  assign redirect_target = align_pc(redirect_pc_i);
  assign pc_next         = pc + PC_INC;
  assign pop             = instr_valid_o && instr_ready_i;
  // Data returned under a redirect belongs to the abandoned path and is never written.
  assign push            = (state == REQ) && imem_ack_i && !redirect_i;
  assign wr_entry        = '{pc: pc, instr: imem_data_i};

  // Occupancy once this cycle's write and any pop have landed; decides back-to-back issue.
  assign occ_after  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  assign room_after = occ_after < (CW+1)'(DEPTH);
  assign has_room   = count < CW'(DEPTH);

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign instr_pc_o    = instr_valid_o ? head.pc    : '0;
  assign count_o       = count;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (push),
    .entry (wr_entry),
    .pop   (pop),
    .flush (redirect_i),
    .head  (head),
    .count (count)
  );

  // Fetch FSM: owns the request handshake, the held request address and the fetch PC.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
      pc          <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_i) begin
            pc <= redirect_target;
            if (start_i) begin
              state       <= REQ;
              imem_req_o  <= 1'b1;
              imem_addr_o <= redirect_target;
            end
          end else if (start_i && has_room) begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc;
          end
        end
        REQ: begin
          if (redirect_i) begin
            pc <= redirect_target;
            if (!imem_ack_i) begin
              // Old request must still complete; keep req/addr stable and drop its data.
              state <= DISCARD;
            end else if (start_i) begin
              imem_addr_o <= redirect_target;
            end else begin
              state      <= IDLE;
              imem_req_o <= 1'b0;
            end
          end else if (imem_ack_i) begin
            pc <= pc_next;
            if (start_i && room_after) begin
              imem_addr_o <= pc_next;
            end else begin
              state      <= IDLE;
              imem_req_o <= 1'b0;
            end
          end
        end
        DISCARD: begin
          // pc holds the pending redirect target; a later redirect simply replaces it.
          if (redirect_i) pc <= redirect_target;
          if (imem_ack_i) begin
            if (start_i) begin
              state       <= REQ;
              imem_addr_o <= redirect_i ? redirect_target : pc;
            end else begin
              state      <= IDLE;
              imem_req_o <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit (DEPTH=4, RESET_PC=0).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [2:0]  count_o;

  int vectors;
  int miscompares;

  instr_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  // Memory contents: word at address A is A ^ 32'hC0DE_0000.
  assign imem_data_i = imem_addr_o ^ 32'hC0DE_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    clk           = 1'b0;
    rst_i         = 1'b0;
    start_i       = 1'b0;
    imem_ack_i    = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;

    // Reset values
    #3;
    chk("rst_req",   32'(imem_req_o),    32'h0);
    chk("rst_addr",  imem_addr_o,        32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_instr", instr_o,            32'h0);
    chk("rst_pc",    instr_pc_o,         32'h0);
    chk("rst_count", 32'(count_o),       32'h0);
    step();
    step();

    // Streaming: ack every cycle, ready=1
    rst_i = 1'b1; start_i = 1'b1; instr_ready_i = 1'b1; imem_ack_i = 1'b1;
    step();
    chk("s_req1",   32'(imem_req_o),    32'h1);
    chk("s_addr1",  imem_addr_o,        32'h0);
    chk("s_valid1", 32'(instr_valid_o), 32'h0);
    step();
    chk("s_addr2",  imem_addr_o,        32'h4);
    chk("s_valid2", 32'(instr_valid_o), 32'h1);
    chk("s_pc2",    instr_pc_o,         32'h0);
    chk("s_instr2", instr_o,            32'hC0DE_0000);
    chk("s_count2", 32'(count_o),       32'h1);
    step();
    chk("s_addr3",  imem_addr_o,        32'h8);
    chk("s_pc3",    instr_pc_o,         32'h4);
    chk("s_instr3", instr_o,            32'hC0DE_0004);
    chk("s_count3", 32'(count_o),       32'h1);
    step();
    chk("s_addr4",  imem_addr_o,        32'hC);
    chk("s_pc4",    instr_pc_o,         32'h8);
    chk("s_instr4", instr_o,            32'hC0DE_0008);

    // Asynchronous reset in the middle of a request
    rst_i = 1'b0;
    #1;
    chk("ar_req",   32'(imem_req_o),    32'h0);
    chk("ar_addr",  imem_addr_o,        32'h0);
    chk("ar_valid", 32'(instr_valid_o), 32'h0);
    chk("ar_instr", instr_o,            32'h0);
    chk("ar_pc",    instr_pc_o,         32'h0);
    chk("ar_count", 32'(count_o),       32'h0);
    step();

    // Fill with ready=0: exactly four requests, then one slot frees -> one more
    rst_i = 1'b1; instr_ready_i = 1'b0;
    step();
    chk("f_addr1", imem_addr_o, 32'h0);
    step(); step(); step();
    chk("f_count4", 32'(count_o),    32'h3);
    chk("f_addr4",  imem_addr_o,     32'hC);
    step();
    chk("f_req5",   32'(imem_req_o), 32'h0);
    chk("f_count5", 32'(count_o),    32'h4);
    chk("f_head5",  instr_pc_o,      32'h0);
    step();
    chk("f_req6",   32'(imem_req_o), 32'h0);
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    chk("f_count7", 32'(count_o),    32'h3);
    chk("f_req7",   32'(imem_req_o), 32'h0);
    chk("f_head7",  instr_pc_o,      32'h4);
    step();
    chk("f_req8",   32'(imem_req_o), 32'h1);
    chk("f_addr8",  imem_addr_o,     32'h10);
    step();
    chk("f_req9",   32'(imem_req_o), 32'h0);
    chk("f_count9", 32'(count_o),    32'h4);

    // Ack latency of three wait cycles per word
    imem_ack_i = 1'b0; instr_ready_i = 1'b1;
    do_reset();
    step();
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 3; w++) begin
        chk("lat_req",  32'(imem_req_o), 32'h1);
        chk("lat_addr", imem_addr_o,     32'(k * 4));
        step();
      end
      imem_ack_i = 1'b1;
      step();
      imem_ack_i = 1'b0;
      chk("lat_next",  imem_addr_o, 32'((k + 1) * 4));
      chk("lat_pc",    instr_pc_o,  32'(k * 4));
      chk("lat_instr", instr_o,     32'(k * 4) ^ 32'hC0DE_0000);
      chk("lat_count", 32'(count_o), 32'h1);
    end

    // Redirect to 0x103 while request at 0x8 is pending
    instr_ready_i = 1'b0; imem_ack_i = 1'b1;
    do_reset();
    step(); step(); step();
    chk("d_count3", 32'(count_o), 32'h2);
    chk("d_addr3",  imem_addr_o,  32'h8);
    imem_ack_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    step();
    redirect_i = 1'b0;
    chk("d_count4", 32'(count_o),    32'h0);
    chk("d_valid4", 32'(instr_valid_o), 32'h0);
    chk("d_req4",   32'(imem_req_o), 32'h1);
    chk("d_addr4",  imem_addr_o,     32'h8);
    step();
    chk("d_addr5",  imem_addr_o,     32'h8);
    imem_ack_i = 1'b1;
    step();
    chk("d_count6", 32'(count_o),    32'h0);
    chk("d_req6",   32'(imem_req_o), 32'h1);
    chk("d_addr6",  imem_addr_o,     32'h100);
    step();
    chk("d_pc7",    instr_pc_o,      32'h100);
    chk("d_instr7", instr_o,         32'hC0DE_0100);
    chk("d_count7", 32'(count_o),    32'h1);
    chk("d_addr7",  imem_addr_o,     32'h104);

    // Redirect coinciding with ack at 0x20 and a pop
    redirect_i = 1'b1; redirect_pc_i = 32'h18;
    step();
    redirect_i = 1'b0;
    chk("r_addr18",  imem_addr_o, 32'h18);
    chk("r_count18", 32'(count_o), 32'h0);
    step(); step();
    chk("r_addr20",  imem_addr_o, 32'h20);
    chk("r_count20", 32'(count_o), 32'h2);
    chk("r_head20",  instr_pc_o,  32'h18);
    redirect_i = 1'b1; redirect_pc_i = 32'h200; instr_ready_i = 1'b1;
    step();
    redirect_i = 1'b0; instr_ready_i = 1'b0;
    chk("r_count",  32'(count_o),       32'h0);
    chk("r_valid",  32'(instr_valid_o), 32'h0);
    chk("r_instr",  instr_o,            32'h0);
    chk("r_pc",     instr_pc_o,         32'h0);
    chk("r_req",    32'(imem_req_o),    32'h1);
    chk("r_addr",   imem_addr_o,        32'h200);
    step();
    chk("r_head",   instr_pc_o,  32'h200);
    chk("r_hinstr", instr_o,     32'hC0DE_0200);
    chk("r_next",   imem_addr_o, 32'h204);

    // PC wrap from 0xFFFF_FFFC, unaligned redirect target
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    step();
    redirect_i = 1'b0;
    chk("w_addr",  imem_addr_o, 32'hFFFF_FFFC);
    chk("w_count", 32'(count_o), 32'h0);
    step();
    chk("w_next",  imem_addr_o, 32'h0000_0000);
    chk("w_pc",    instr_pc_o,  32'hFFFF_FFFC);
    chk("w_instr", instr_o,     32'h3F21_FFFC);

    // start_i falls in REQ: request completes, no further issue
    imem_ack_i = 1'b0; start_i = 1'b0;
    step();
    chk("st_req1",   32'(imem_req_o), 32'h1);
    chk("st_addr1",  imem_addr_o,     32'h0);
    imem_ack_i = 1'b1;
    step();
    imem_ack_i = 1'b0;
    chk("st_req2",   32'(imem_req_o), 32'h0);
    chk("st_count2", 32'(count_o),    32'h2);
    step();
    chk("st_req3",   32'(imem_req_o), 32'h0);

    // Redirect while idle, then start
    redirect_i = 1'b1; redirect_pc_i = 32'h400;
    step();
    redirect_i = 1'b0;
    chk("i_count", 32'(count_o),    32'h0);
    chk("i_req",   32'(imem_req_o), 32'h0);
    start_i = 1'b1;
    step();
    chk("i_req2",  32'(imem_req_o), 32'h1);
    chk("i_addr2", imem_addr_o,     32'h400);

    // Two redirects while discarding: the later target wins
    redirect_i = 1'b1; redirect_pc_i = 32'h500;
    step();
    redirect_pc_i = 32'h600;
    step();
    redirect_i = 1'b0;
    chk("lw_addr", imem_addr_o,     32'h400);
    chk("lw_req",  32'(imem_req_o), 32'h1);
    imem_ack_i = 1'b1;
    step();
    imem_ack_i = 1'b0;
    chk("lw_new",   imem_addr_o,  32'h600);
    chk("lw_count", 32'(count_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
